shift_register: RTL and testbench
=================================

Name: shift_register

Overview:
- Bring-up shift-register block, one clock domain.
- Three noisy, asynchronous inputs each pass through an input_conditioner sub-module: serial data, peripheral-clock, parallel-load button.
- Conditioned events drive an N-bit shift register with parallel load, parallel output and serial output.
- Sits between board switches/buttons and LEDs / serial pins.

Parameters:
- WIDTH, 8: shift register width.
- WAIT_TIME, 3: debounce stability time, in clk cycles.
- COUNTER_WIDTH, 3: debounce counter width; must hold WAIT_TIME.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- noisy_serial_in  in  1  raw serial data (switch); asynchronous.
- noisy_periph_clk  in  1  raw peripheral clock (switch); asynchronous.
- noisy_parallel_load  in  1  raw load button; asynchronous.
- parallel_data_in  in  WIDTH  load value.
- parallel_data_out  out  WIDTH  shift register contents.
- serial_data_out  out  1  MSB of the shift register.

Behaviour:
- Reset (synchronous, active-high), on a rising clk edge with reset=1:
  - Synchronizer flops, counters, conditioned outputs and edge pulses all go to 0.
  - Shift register goes to 0.
  - parallel_data_out=0 and serial_data_out=0 on the next cycle.
  - Reset overrides any load or shift in progress.
- input_conditioner (one per noisy input):
  - Two-flop synchronizer: sync0 then sync1.
  - When sync1 == conditioned: counter <= 0.
  - When sync1 != conditioned and counter < WAIT_TIME: counter increments.
  - When sync1 != conditioned and counter == WAIT_TIME: conditioned <= sync1, counter <= 0, and a one-cycle edge pulse is asserted.
  - Edge pulses: positiveedge for 0->1, negativeedge for 1->0.
  - Latency: a raw change first sampled at edge N and held stable gives conditioned and the pulse updating at edge N+WAIT_TIME+2. With defaults that is 5 cycles after sampling, i.e. 6 edges including the sampling edge.
  - Glitches: any excursion that reverts before the counter reaches WAIT_TIME clears the counter. No output change, no pulse.
  - Pulses are registered and last exactly one cycle.
  - At most one pulse per transition; never both pulses in the same cycle.
- shift_register core:
  - parallel_load = negativeedge of the conditioned button, so the load happens on button release.
  - shift = positiveedge of the conditioned peripheral clock.
  - On parallel_load: reg <= parallel_data_in.
  - Else on shift: reg <= {reg[WIDTH-2:0], conditioned serial_in}, i.e. shift left with the new bit into the LSB.
  - Else: hold.
  - Simultaneous load and shift: load wins and the shift is dropped.
  - serial_data_out = reg[WIDTH-1]; parallel_data_out = reg. Both come straight from the register, no combinational path from the inputs.
  - The serial bit is sampled from the conditioned serial level on the cycle of the shift pulse. It must have settled at least WAIT_TIME+3 cycles before the periph-clock edge is conditioned.

Decomposition:
- Shared package: default constants for WIDTH, WAIT_TIME and COUNTER_WIDTH.
- Sub-module input_conditioner.
  - Ports: clk, reset, noisy_signal, conditioned, positive_edge, negative_edge.
  - Parameters: WAIT_TIME, COUNTER_WIDTH.
  - Instantiated three times.
- The unused edge/level outputs of each instance are left unconnected.

Test Plan:
- Reset: assert reset for 2 cycles with all inputs toggling -> parallel_data_out=0x00, serial_data_out=0, no pulses.
- Parallel load: parallel_data_in=0xA5; raise the button for 50 cycles, then release -> 0xA5 (10100101) appears exactly WAIT_TIME+3 edges after the release is sampled; serial_data_out=1.
- Shift in 0: serial=0, then a periph_clk 0->1 held 5+ cycles -> exactly one shift, 0xA5 becomes 0x4A; serial_data_out=0. The later 1->0 does not shift.
- Shift in 1: set serial=1, wait 10 cycles, then pulse periph_clk -> 0x4A becomes 0x95; serial_data_out=1.
- Reload: press and release the button -> 0x95 becomes 0xA5.
- Debounce and priority:
  - 2-cycle glitch on periph_clk -> no shift; the conditioner's conditioned output stays 0.
  - Force load and shift events in the same cycle -> register = parallel_data_in.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared defaults and the core-operation encoding for the shift_register block.
//   DEFAULT_WIDTH         : shift register width
//   DEFAULT_WAIT_TIME     : debounce stability time in clk cycles
//   DEFAULT_COUNTER_WIDTH : debounce counter width (must hold WAIT_TIME)
package shift_register_pkg;

  localparam int unsigned DEFAULT_WIDTH         = 8;
  localparam int unsigned DEFAULT_WAIT_TIME     = 3;
  localparam int unsigned DEFAULT_COUNTER_WIDTH = 3;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2
  } core_op_e;

  // Load has priority over shift; a coincident shift is dropped.
  function automatic core_op_e select_op(input logic load, input logic shift);
    if (load)       return OP_LOAD;
    else if (shift) return OP_SHIFT;
    else            return OP_HOLD;
  endfunction

endpackage

// File: rtl/input_conditioner.sv
// Synchronizes and debounces one asynchronous noisy input.
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset
//   noisy_signal  : raw asynchronous input
//   conditioned   : debounced, synchronized level
//   positive_edge : one-cycle pulse when conditioned goes 0->1
//   negative_edge : one-cycle pulse when conditioned goes 1->0
module input_conditioner #(
  parameter int unsigned WAIT_TIME     = 3,
  parameter int unsigned COUNTER_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy_signal,
  output logic conditioned,
  output logic positive_edge,
  output logic negative_edge
);

  localparam logic [COUNTER_WIDTH-1:0] LP_WAIT = COUNTER_WIDTH'(WAIT_TIME);

  logic                     r_sync0;
  logic                     r_sync1;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic                     r_conditioned;
  logic                     r_pos_edge;
  logic                     r_neg_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0       <= 1'b0;
      r_sync1       <= 1'b0;
      r_counter     <= '0;
      r_conditioned <= 1'b0;
      r_pos_edge    <= 1'b0;
      r_neg_edge    <= 1'b0;
    end else begin
      r_sync0    <= noisy_signal;
      r_sync1    <= r_sync0;
      r_pos_edge <= 1'b0;
      r_neg_edge <= 1'b0;
      if (r_sync1 == r_conditioned) begin
        // Any excursion that reverts early clears the stability count.
        r_counter <= '0;
      end else if (r_counter == LP_WAIT) begin
        r_conditioned <= r_sync1;
        r_counter     <= '0;
        r_pos_edge    <= r_sync1;
        r_neg_edge    <= ~r_sync1;
      end else begin
        r_counter <= r_counter + 1'b1;
      end
    end
  end

  assign conditioned   = r_conditioned;
  assign positive_edge = r_pos_edge;
  assign negative_edge = r_neg_edge;

endmodule

// File: rtl/shift_register.sv
// Bring-up shift register driven by three debounced asynchronous inputs.
// Ports:
//   clk                 : system clock, rising edge
//   reset               : synchronous active-high reset
//   noisy_serial_in     : raw serial data bit
//   noisy_periph_clk    : raw peripheral clock; each conditioned rise shifts once
//   noisy_parallel_load : raw load button; load happens on conditioned release
//   parallel_data_in    : value loaded on button release
//   parallel_data_out   : register contents
//   serial_data_out     : register MSB
module shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH         = DEFAULT_WIDTH,
  parameter int unsigned WAIT_TIME     = DEFAULT_WAIT_TIME,
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             noisy_serial_in,
  input  logic             noisy_periph_clk,
  input  logic             noisy_parallel_load,
  input  logic [WIDTH-1:0] parallel_data_in,
  output logic [WIDTH-1:0] parallel_data_out,
  output logic             serial_data_out
);

  logic w_serial_level;
  logic w_shift;
  logic w_load;
  core_op_e w_op;
  logic [WIDTH-1:0] r_data;

  input_conditioner #(
    .WAIT_TIME    (WAIT_TIME),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_serial (
    .clk          (clk),
    .reset        (reset),
    .noisy_signal (noisy_serial_in),
    .conditioned  (w_serial_level),
    .positive_edge(),
    .negative_edge()
  );

  input_conditioner #(
    .WAIT_TIME    (WAIT_TIME),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_periph (
    .clk          (clk),
    .reset        (reset),
    .noisy_signal (noisy_periph_clk),
    .conditioned  (),
    .positive_edge(w_shift),
    .negative_edge()
  );

  input_conditioner #(
    .WAIT_TIME    (WAIT_TIME),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_load (
    .clk          (clk),
    .reset        (reset),
    .noisy_signal (noisy_parallel_load),
    .conditioned  (),
    .positive_edge(),
    .negative_edge(w_load)
  );

  always_comb begin
    w_op = select_op(w_load, w_shift);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else begin
      unique case (w_op)
        OP_LOAD:  r_data <= parallel_data_in;
        OP_SHIFT: r_data <= {r_data[WIDTH-2:0], w_serial_level};
        default:  r_data <= r_data;
      endcase
    end
  end

  assign parallel_data_out = r_data;
  assign serial_data_out   = r_data[WIDTH-1];

endmodule

// File: tb/tb_shift_register.sv
module tb_shift_register;

  logic       clk = 1'b0;
  logic       reset;
  logic       noisy_serial_in;
  logic       noisy_periph_clk;
  logic       noisy_parallel_load;
  logic [7:0] parallel_data_in;
  logic [7:0] parallel_data_out;
  logic       serial_data_out;

  int checks   = 0;
  int failures = 0;

  shift_register #(
    .WIDTH        (8),
    .WAIT_TIME    (3),
    .COUNTER_WIDTH(3)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .noisy_serial_in    (noisy_serial_in),
    .noisy_periph_clk   (noisy_periph_clk),
    .noisy_parallel_load(noisy_parallel_load),
    .parallel_data_in   (parallel_data_in),
    .parallel_data_out  (parallel_data_out),
    .serial_data_out    (serial_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_load;
    logic [7:0] pdata;
    logic       serial;
    logic [7:0] exp_out;
    logic       exp_ser;
  } vec_t;

  vec_t vecs[7];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    parallel_data_in    = d;
    noisy_parallel_load = 1'b1;
    cyc(10);
    noisy_parallel_load = 1'b0;
    cyc(12);
  endtask

  task automatic do_shift(input logic s);
    noisy_serial_in  = s;
    cyc(10);
    noisy_periph_clk = 1'b1;
    cyc(8);
    noisy_periph_clk = 1'b0;
    cyc(8);
  endtask

  task automatic reset_toggling();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      noisy_serial_in     = ~noisy_serial_in;
      noisy_periph_clk    = ~noisy_periph_clk;
      noisy_parallel_load = ~noisy_parallel_load;
      parallel_data_in    = ~parallel_data_in;
      cyc(1);
    end
  endtask

  initial begin
    logic glitch_bad;
    reset               = 1'b1;
    noisy_serial_in     = 1'b0;
    noisy_periph_clk    = 1'b0;
    noisy_parallel_load = 1'b0;
    parallel_data_in    = 8'h5C;

    // Reset with inputs toggling
    reset_toggling();
    check("reset_pdo", parallel_data_out, 8'h00);
    check("reset_sdo", {7'b0, serial_data_out}, 8'h00);
    noisy_serial_in     = 1'b0;
    noisy_periph_clk    = 1'b0;
    noisy_parallel_load = 1'b0;
    reset               = 1'b0;
    cyc(12);
    check("idle_after_reset", parallel_data_out, 8'h00);

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1};
    vecs[1] = '{1'b0, 8'hA5, 1'b0, 8'h4A, 1'b0};
    vecs[2] = '{1'b0, 8'hA5, 1'b1, 8'h95, 1'b1};
    vecs[3] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[4] = '{1'b0, 8'hA5, 1'b1, 8'h4B, 1'b0};
    vecs[5] = '{1'b0, 8'hA5, 1'b1, 8'h97, 1'b1};
    vecs[6] = '{1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0};

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_load) do_load(vecs[i].pdata);
      else                 do_shift(vecs[i].serial);
      check($sformatf("vec%0d_pdo", i), parallel_data_out, vecs[i].exp_out);
      check($sformatf("vec%0d_sdo", i), {7'b0, serial_data_out}, {7'b0, vecs[i].exp_ser});
    end

    // Load latency: new value appears exactly 7 edges after release is driven
    parallel_data_in    = 8'h81;
    noisy_parallel_load = 1'b1;
    cyc(10);
    noisy_parallel_load = 1'b0;
    cyc(6);
    check("latency_before", parallel_data_out, 8'h3C);
    cyc(1);
    check("latency_after", parallel_data_out, 8'h81);
    cyc(6);

    // 2-cycle glitch on the peripheral clock is filtered
    noisy_periph_clk = 1'b1;
    cyc(2);
    noisy_periph_clk = 1'b0;
    glitch_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dut.u_periph.conditioned !== 1'b0) glitch_bad = 1'b1;
      cyc(1);
    end
    check("glitch_conditioned", {7'b0, glitch_bad}, 8'h00);
    check("glitch_pdo", parallel_data_out, 8'h81);

    // Coincident load and shift: load wins
    noisy_serial_in     = 1'b0;
    parallel_data_in    = 8'hF0;
    noisy_parallel_load = 1'b1;
    cyc(10);
    noisy_parallel_load = 1'b0;
    noisy_periph_clk    = 1'b1;
    cyc(12);
    check("simul_pdo", parallel_data_out, 8'hF0);
    noisy_periph_clk = 1'b0;
    cyc(10);
    check("simul_fall_pdo", parallel_data_out, 8'hF0);
    check("simul_sdo", {7'b0, serial_data_out}, 8'h01);

    // Reset overrides a non-zero register
    reset_toggling();
    check("midreset_pdo", parallel_data_out, 8'h00);
    check("midreset_sdo", {7'b0, serial_data_out}, 8'h00);
    noisy_serial_in     = 1'b0;
    noisy_periph_clk    = 1'b0;
    noisy_parallel_load = 1'b0;
    reset               = 1'b0;
    cyc(12);
    check("post_midreset_pdo", parallel_data_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
